// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register feeding the EXE stage and its forwarding unit; 1-cycle latency, registered outputs only.
// Backpressure: freeze holds all state, but flush still wins and kills the entering instruction.
// ID_EXE_PERF_CNT_EN builds the saturating bubble/flush counters; otherwise those ports read 0.
module id_exe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CMD_W  = 4,
   parameter int IMM_W  = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              freeze,
   input  logic              hazard,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_val1,
   input  logic [DATA_W-1:0] id_val2,
   input  logic [IMM_W-1:0]  id_imm,
   input  logic [REG_W-1:0]  id_src1,
   input  logic [REG_W-1:0]  id_src2,
   input  logic [REG_W-1:0]  id_dest,
   input  logic [CMD_W-1:0]  id_exe_cmd,
   input  logic              id_mem_r_en,
   input  logic              id_mem_w_en,
   input  logic              id_wb_en,
   input  logic              id_b,
   input  logic              id_s,
   output logic              exe_valid,
   output logic [DATA_W-1:0] exe_pc,
   output logic [DATA_W-1:0] exe_val1,
   output logic [DATA_W-1:0] exe_val2,
   output logic [IMM_W-1:0]  exe_imm,
   output logic [REG_W-1:0]  exe_src1,
   output logic [REG_W-1:0]  exe_src2,
   output logic [REG_W-1:0]  exe_dest,
   output logic [CMD_W-1:0]  exe_exe_cmd,
   output logic              exe_mem_r_en,
   output logic              exe_mem_w_en,
   output logic              exe_wb_en,
   output logic              exe_b,
   output logic              exe_s,
   output logic [15:0]       bubble_cnt,
   output logic [15:0]       flush_cnt
);

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] val1;
      logic [DATA_W-1:0] val2;
      logic [IMM_W-1:0]  imm;
      logic [REG_W-1:0]  src1;
      logic [REG_W-1:0]  src2;
      logic [REG_W-1:0]  dest;
      logic [CMD_W-1:0]  cmd;
      logic              mem_r_en;
      logic              mem_w_en;
      logic              wb_en;
      logic              b;
      logic              s;
   } stage_t;

   stage_t id_dat;
   stage_t exe_dat;
   logic   bubble_load;

   always_comb begin
      id_dat = '{valid: id_valid, pc: id_pc, val1: id_val1, val2: id_val2,
                 imm: id_imm, src1: id_src1, src2: id_src2, dest: id_dest,
                 cmd: id_exe_cmd, mem_r_en: id_mem_r_en, mem_w_en: id_mem_w_en,
                 wb_en: id_wb_en, b: id_b, s: id_s};
   end

   // A bubble is all-zero, so control bits and tags are inherently gated by valid.
   assign bubble_load = flush || hazard || !id_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exe_dat <= '0;
      end else if (flush || !freeze) begin
         exe_dat <= bubble_load ? '0 : id_dat;
      end
   end

   assign exe_valid    = exe_dat.valid;
   assign exe_pc       = exe_dat.pc;
   assign exe_val1     = exe_dat.val1;
   assign exe_val2     = exe_dat.val2;
   assign exe_imm      = exe_dat.imm;
   assign exe_src1     = exe_dat.src1;
   assign exe_src2     = exe_dat.src2;
   assign exe_dest     = exe_dat.dest;
   assign exe_exe_cmd  = exe_dat.cmd;
   assign exe_mem_r_en = exe_dat.mem_r_en;
   assign exe_mem_w_en = exe_dat.mem_w_en;
   assign exe_wb_en    = exe_dat.wb_en;
   assign exe_b        = exe_dat.b;
   assign exe_s        = exe_dat.s;

`ifdef ID_EXE_PERF_CNT_EN
   logic [15:0] bubble_q;
   logic [15:0] flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_q <= '0;
         flush_q  <= '0;
      end else begin
         if (flush && flush_q != 16'hFFFF)
            flush_q <= flush_q + 16'd1;
         if (hazard && !flush && !freeze && bubble_q != 16'hFFFF)
            bubble_q <= bubble_q + 16'd1;
      end
   end

   assign bubble_cnt = bubble_q;
   assign flush_cnt  = flush_q;
`else
   assign bubble_cnt = '0;
   assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Randomized and directed bench for id_exe_reg against a rule-level reference model.
module tb_id_exe_reg;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        freeze = 1'b0, hazard = 1'b0, flush = 1'b0, id_valid = 1'b0;
   logic [31:0] id_pc = '0, id_val1 = '0, id_val2 = '0;
   logic [23:0] id_imm = '0;
   logic [4:0]  id_src1 = '0, id_src2 = '0, id_dest = '0;
   logic [3:0]  id_exe_cmd = '0;
   logic        id_mem_r_en = 1'b0, id_mem_w_en = 1'b0, id_wb_en = 1'b0, id_b = 1'b0, id_s = 1'b0;

   logic        exe_valid, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s;
   logic [31:0] exe_pc, exe_val1, exe_val2;
   logic [23:0] exe_imm;
   logic [4:0]  exe_src1, exe_src2, exe_dest;
   logic [3:0]  exe_exe_cmd;
   logic [15:0] bubble_cnt, flush_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_exe_reg dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .hazard(hazard), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_val1(id_val1), .id_val2(id_val2),
      .id_imm(id_imm), .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
      .id_exe_cmd(id_exe_cmd), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
      .id_wb_en(id_wb_en), .id_b(id_b), .id_s(id_s),
      .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_val1(exe_val1), .exe_val2(exe_val2),
      .exe_imm(exe_imm), .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
      .exe_exe_cmd(exe_exe_cmd), .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
      .exe_wb_en(exe_wb_en), .exe_b(exe_b), .exe_s(exe_s),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   // Reference: the EXE-side instruction as a flat field list, plus event tallies.
   logic [31:0] m_pc, m_val1, m_val2;
   logic [23:0] m_imm;
   logic [4:0]  m_src1, m_src2, m_dest;
   logic [3:0]  m_cmd;
   logic        m_valid, m_r, m_w, m_wb, m_b, m_s;
   int          m_bub, m_fl;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_bubble();
      {m_valid, m_pc, m_val1, m_val2, m_imm, m_src1, m_src2, m_dest, m_cmd} = '0;
      {m_r, m_w, m_wb, m_b, m_s} = '0;
   endtask

   task automatic model_reset();
      model_bubble();
      m_bub = 0;
      m_fl  = 0;
   endtask

   task automatic model_edge();
      bit take_id;
      take_id = !flush && !freeze && !hazard && id_valid;
      if (take_id) begin
         m_valid = 1'b1; m_pc = id_pc; m_val1 = id_val1; m_val2 = id_val2; m_imm = id_imm;
         m_src1 = id_src1; m_src2 = id_src2; m_dest = id_dest; m_cmd = id_exe_cmd;
         m_r = id_mem_r_en; m_w = id_mem_w_en; m_wb = id_wb_en; m_b = id_b; m_s = id_s;
      end else if (flush || !freeze) begin
         model_bubble();
      end
`ifdef ID_EXE_PERF_CNT_EN
      if (flush) m_fl = (m_fl < 65535) ? m_fl + 1 : 65535;
      if (hazard && !flush && !freeze) m_bub = (m_bub < 65535) ? m_bub + 1 : 65535;
`endif
   endtask

   task automatic check_all(input string ctx);
      check({ctx, ".valid"}, exe_valid, m_valid);
      check({ctx, ".pc"}, exe_pc, m_pc);
      check({ctx, ".val1"}, exe_val1, m_val1);
      check({ctx, ".val2"}, exe_val2, m_val2);
      check({ctx, ".imm"}, exe_imm, m_imm);
      check({ctx, ".src1"}, exe_src1, m_src1);
      check({ctx, ".src2"}, exe_src2, m_src2);
      check({ctx, ".dest"}, exe_dest, m_dest);
      check({ctx, ".cmd"}, exe_exe_cmd, m_cmd);
      check({ctx, ".ctrl"}, {exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s},
            {m_r, m_w, m_wb, m_b, m_s});
      check({ctx, ".gate"}, (exe_valid == 1'b0) && (exe_mem_r_en | exe_mem_w_en | exe_wb_en | exe_b | exe_s), 0);
      check({ctx, ".bubble_cnt"}, bubble_cnt, m_bub[15:0]);
      check({ctx, ".flush_cnt"}, flush_cnt, m_fl[15:0]);
   endtask

   task automatic rand_id();
      id_pc = $urandom; id_val1 = $urandom; id_val2 = $urandom; id_imm = 24'($urandom);
      id_src1 = 5'($urandom); id_src2 = 5'($urandom); id_dest = 5'($urandom);
      id_exe_cmd = 4'($urandom);
      {id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s} = 5'($urandom);
   endtask

   task automatic step(input string ctx);
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      check_all(ctx);
   endtask

   initial begin
      model_reset();
      // Reset with busy inputs
      rand_id(); id_valid = 1'b1;
      #12;
      check_all("reset");
      @(negedge clk);
      id_valid = 1'b1; id_pc = 32'h10; id_dest = 5'd3; id_wb_en = 1'b1;
      rst_n = 1'b1;
      step("first");
      check("first_pc", exe_pc, 32'h10);
      check("first_dest", exe_dest, 5'd3);
      check("first_wb", exe_wb_en, 1'b1);
      check("first_valid", exe_valid, 1'b1);

      // Freeze hold
      id_pc = 32'h20;
      step("load20");
      freeze = 1'b1; id_pc = 32'h24;
      for (int i = 0; i < 3; i++) begin
         step("freeze");
         check("freeze_pc", exe_pc, 32'h20);
      end
      freeze = 1'b0;
      step("unfreeze");
      check("unfreeze_pc", exe_pc, 32'h24);

      // Hazard bubble
      hazard = 1'b1; id_mem_r_en = 1'b1; id_wb_en = 1'b1; id_src1 = 5'd7;
      step("hazard");
      check("hz_valid", exe_valid, 1'b0);
      check("hz_wb", exe_wb_en, 1'b0);
      check("hz_mem_r", exe_mem_r_en, 1'b0);
      check("hz_src1", exe_src1, 5'd0);
`ifdef ID_EXE_PERF_CNT_EN
      check("hz_bubble_cnt", bubble_cnt, 16'd1);
`endif
      hazard = 1'b0;
      step("reload");

      // Flush beats freeze and hazard
      freeze = 1'b1; hazard = 1'b1; flush = 1'b1;
      step("flush_all");
      check("fl_valid", exe_valid, 1'b0);
      check("fl_pc", exe_pc, 32'h0);
`ifdef ID_EXE_PERF_CNT_EN
      check("fl_flush_cnt", flush_cnt, 16'd1);
      check("fl_bubble_cnt", bubble_cnt, 16'd1);
`endif
      freeze = 1'b0; hazard = 1'b0; flush = 1'b0;

      // Invalid instruction on a load cycle
      id_valid = 1'b0; id_wb_en = 1'b1; id_s = 1'b1;
      step("invalid");
      check("inv_wb", exe_wb_en, 1'b0);
      check("inv_s", exe_s, 1'b0);
      check("inv_valid", exe_valid, 1'b0);

      // Reset landing in the middle of a freeze
      id_valid = 1'b1; rand_id();
      step("pre_rst");
      freeze = 1'b1;
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all("rst_mid_freeze");
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst_freeze");
      check("post_rst_valid", exe_valid, 1'b0);
      freeze = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         rand_id();
         id_valid = ($urandom_range(3) != 0);
         freeze   = ($urandom_range(3) == 0);
         hazard   = ($urandom_range(4) == 0);
         flush    = ($urandom_range(7) == 0);
         step("rand");
      end
      freeze = 1'b0; flush = 1'b0;

`ifdef ID_EXE_PERF_CNT_EN
      // Bubble counter saturation
      hazard = 1'b1;
      for (int n = 0; n < 65540; n++) begin
         @(posedge clk);
         model_edge();
      end
      @(negedge clk);
      check("sat_bubble_cnt", bubble_cnt, 16'hFFFF);
      step("sat_hold");
      check("sat_bubble_hold", bubble_cnt, 16'hFFFF);
      hazard = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- ID/EXE pipeline register directly upstream of the EXE-stage forwarding unit.
- Latches decoded ID-stage operands, control bits and register tags each cycle.
- Presents the latched values to EXE, including the src1/src2/dest tags and wb_en the forwarding unit compares.
- Supports freeze (hold), hazard bubble insertion and branch flush, with a valid bit marking real instructions.

Parameters:
- DATA_W, 32, width of pc and operand values
- REG_W, 5, width of register tags src1/src2/dest
- CMD_W, 4, width of ALU execute command
- IMM_W, 24, width of immediate/offset field

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- freeze  in  1  hold all state (downstream memory stall)
- hazard  in  1  load-use hazard from ID; insert bubble
- flush  in  1  taken branch in EXE; kill instruction entering EXE
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DATA_W  instruction PC
- id_val1  in  DATA_W  register-file value for src1
- id_val2  in  DATA_W  register-file value for src2
- id_imm  in  IMM_W  immediate/offset
- id_src1  in  REG_W  source-1 tag
- id_src2  in  REG_W  source-2 tag
- id_dest  in  REG_W  destination tag
- id_exe_cmd  in  CMD_W  ALU command
- id_mem_r_en  in  1  load
- id_mem_w_en  in  1  store
- id_wb_en  in  1  writes register file
- id_b  in  1  branch
- id_s  in  1  update status flags
- exe_valid, exe_pc, exe_val1, exe_val2, exe_imm, exe_src1, exe_src2, exe_dest, exe_exe_cmd, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s  out  (widths as inputs)  registered copies
- bubble_cnt  out  16  bubbles inserted (optional feature)
- flush_cnt  out  16  flushes applied (optional feature)

Behaviour:
- Reset: rst_n low asynchronously clears every output to 0, counters included. Release takes effect at the next rising clk.
- Each rising clk, exactly one action is taken, in priority order flush > freeze > hazard > load.
- flush=1: load a bubble. Bubble = every exe_* output 0, including data and tags. Overrides freeze, so a branch is never lost during a stall.
- freeze=1 (no flush): all outputs hold their current values.
- hazard=1 (no flush or freeze): load a bubble. The ID instruction is held upstream and re-presented next cycle.
- Otherwise: load all id_* fields.
- Load of an invalid instruction: id_valid=0 on a load cycle loads a bubble regardless of the other id_* values.
- Control gating: exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b and exe_s can be 1 only when exe_valid=1. The forwarding unit never matches on a bubble.
- Latency: 1 cycle ID to EXE. No combinational path from any input to any output.
- Simultaneous flush+hazard+freeze resolves to a bubble (flush rule).
- Reset asserted mid-freeze clears all state immediately. No stale instruction reappears after reset.

Optional Feature:
- Macro: ID_EXE_PERF_CNT_EN.
- Defined:
  - bubble_cnt increments by 1 on each clk edge where hazard produces a bubble (hazard=1, flush=0, freeze=0).
  - flush_cnt increments on each edge where flush=1.
  - Both counters saturate at 16'hFFFF and do not wrap.
  - Both are unaffected by freeze hold cycles and are cleared by rst_n.
- Undefined: both ports are present but tied to 0, and no counter flops are built.

Test Plan:
- Reset: rst_n=0 with nonzero id_* inputs → all outputs 0; first edge after release with id_valid=1, id_pc=32'h10, id_dest=5'd3, id_wb_en=1 → exe_pc=32'h10, exe_dest=3, exe_wb_en=1, exe_valid=1.
- Freeze: load pc=32'h20, then freeze=1 for 3 cycles with id_pc=32'h24 → exe_pc stays 32'h20; freeze drops → exe_pc=32'h24 next edge.
- Hazard bubble: hazard=1 with id_mem_r_en=1, id_wb_en=1, id_src1=5'd7 → exe_valid=0, exe_wb_en=0, exe_mem_r_en=0, exe_src1=0; bubble_cnt=1 when the feature is enabled.
- Flush vs freeze: freeze=1, flush=1, hazard=1 on the same edge → bubble loaded; flush_cnt=1 and bubble_cnt unchanged when the feature is enabled.
- Invalid load: id_valid=0, id_wb_en=1, id_s=1 → exe_wb_en=0, exe_s=0, exe_valid=0.
- Counter saturation (feature on): hold hazard=1 for 65540 cycles → bubble_cnt=16'hFFFF and remains there.
